// File: rtl/mips_multi_pkg.sv
// Shared types and constants for the multicycle MIPS main controller:
// FSM state encoding, opcode/funct values, ALU codes and ALU source-B selects.
package mips_multi_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_ALU_WB,
    S_BRANCH,
    S_ADDI_EX,
    S_ADDI_WB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct decoder: maps Funct to an ALU operation code and flags
// whether the funct is one the controller supports.
module mips_alu_decoder
  import mips_multi_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       valid
);

  always_comb begin
    alu_control = ALU_ADD;
    valid       = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_NOR:  alu_control = ALU_NOR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multi_control.sv
// Moore main controller for the multicycle MIPS datapath, one state per clock.
// Define MIPS_MULTI_CTRL_PERF_EN to build the cycle/instruction counters.
module mips_multi_control
  import mips_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             stall,
  output logic             PC_write,
  output logic             Mem_write,
  output logic             IR_write,
  output logic             Reg_write,
  output logic             Branch,
  output logic             lorD_mux,
  output logic             Reg_Dst_mux,
  output logic             Mem_reg_mux,
  output logic             ALU_srcA_mux,
  output logic [1:0]       ALU_srcB_mux,
  output logic [3:0]       ALU_control,
  output logic             Pc_src_mux,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  state_t     state, state_next;
  logic [3:0] r_alu;
  logic       r_valid;
  logic       pc_w, mem_w, ir_w, reg_w, br, ill;

  // Branch gating lives in the datapath; the flag is accepted but not used here.
  logic unused_zero;
  assign unused_zero = Zero;

  mips_alu_decoder u_alu_dec (
    .funct       (Funct),
    .alu_control (r_alu),
    .valid       (r_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    pc_w         = 1'b0;
    mem_w        = 1'b0;
    ir_w         = 1'b0;
    reg_w        = 1'b0;
    br           = 1'b0;
    ill          = 1'b0;
    lorD_mux     = 1'b0;
    Reg_Dst_mux  = 1'b0;
    Mem_reg_mux  = 1'b0;
    ALU_srcA_mux = 1'b0;
    ALU_srcB_mux = SRCB_B;
    ALU_control  = ALU_AND;
    Pc_src_mux   = 1'b0;
    case (state)
      S_INIT: state_next = S_FETCH;
      S_FETCH: begin
        ir_w         = 1'b1;
        pc_w         = 1'b1;
        ALU_srcB_mux = SRCB_FOUR;
        ALU_control  = ALU_ADD;
        state_next   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed here speculatively and parked in ALUOut.
        ALU_srcB_mux = SRCB_IMM_SH;
        ALU_control  = ALU_ADD;
        case (Op)
          OP_RTYPE:     state_next = S_EXEC_R;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDI_EX;
          default: begin
            ill        = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALU_srcA_mux = 1'b1;
        ALU_srcB_mux = SRCB_IMM;
        ALU_control  = ALU_ADD;
        state_next   = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        lorD_mux   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        reg_w       = 1'b1;
        Mem_reg_mux = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWR: begin
        lorD_mux   = 1'b1;
        mem_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        ALU_srcA_mux = 1'b1;
        ALU_srcB_mux = SRCB_B;
        if (r_valid) begin
          ALU_control = r_alu;
          state_next  = S_ALU_WB;
        end else begin
          ALU_control = ALU_ADD;
          ill         = 1'b1;
          state_next  = S_FETCH;
        end
      end
      S_ALU_WB: begin
        reg_w       = 1'b1;
        Reg_Dst_mux = 1'b1;
        state_next  = S_FETCH;
      end
      S_BRANCH: begin
        ALU_srcA_mux = 1'b1;
        ALU_srcB_mux = SRCB_B;
        ALU_control  = ALU_SUB;
        Pc_src_mux   = 1'b1;
        br           = 1'b1;
        state_next   = S_FETCH;
      end
      S_ADDI_EX: begin
        ALU_srcA_mux = 1'b1;
        ALU_srcB_mux = SRCB_IMM;
        ALU_control  = ALU_ADD;
        state_next   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_INIT;
    endcase
    if (stall) state_next = state;
  end

  // Stall masks every side-effecting strobe; mux selects keep the held state's values.
  assign PC_write   = pc_w  & ~stall;
  assign Mem_write  = mem_w & ~stall;
  assign IR_write   = ir_w  & ~stall;
  assign Reg_write  = reg_w & ~stall;
  assign Branch     = br    & ~stall;
  assign illegal_op = ill   & ~stall;

`ifdef MIPS_MULTI_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (state == S_FETCH && !stall) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mips_multi_control.sv
// Self-checking bench for mips_multi_control: per-instruction expected output
// sequences from a table model, randomized instruction mix and stalls.
module tb_mips_multi_control;

  localparam int CNT_W = 32;
`ifdef MIPS_MULTI_CTRL_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110, A_SLT = 4'b0111, A_NOR = 4'b1100;
  // Bits that survive a stall: every mux select and ALU_control, no strobes.
  localparam logic [16:0] KEEP = 17'h00FFE;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic zero = 1'b0, stall = 1'b0;
  logic PC_write, Mem_write, IR_write, Reg_write, Branch;
  logic lorD_mux, Reg_Dst_mux, Mem_reg_mux, ALU_srcA_mux, Pc_src_mux, illegal_op;
  logic [1:0] ALU_srcB_mux;
  logic [3:0] ALU_control;
  logic [CNT_W-1:0] instr_count, cycle_count;
  logic [16:0] obs_w;

  int checks = 0;
  int fails = 0;
  int m_cycles = 0;
  int m_instrs = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  mips_multi_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Zero(zero), .stall(stall),
    .PC_write(PC_write), .Mem_write(Mem_write), .IR_write(IR_write),
    .Reg_write(Reg_write), .Branch(Branch), .lorD_mux(lorD_mux),
    .Reg_Dst_mux(Reg_Dst_mux), .Mem_reg_mux(Mem_reg_mux),
    .ALU_srcA_mux(ALU_srcA_mux), .ALU_srcB_mux(ALU_srcB_mux),
    .ALU_control(ALU_control), .Pc_src_mux(Pc_src_mux), .illegal_op(illegal_op),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  assign obs_w = {PC_write, Mem_write, IR_write, Reg_write, Branch, lorD_mux,
                  Reg_Dst_mux, Mem_reg_mux, ALU_srcA_mux, ALU_srcB_mux,
                  ALU_control, Pc_src_mux, illegal_op};

  function automatic logic [16:0] mk(input logic pcw, mw, irw, rw, br, lord, rd, mr, sa,
                                     input logic [1:0] sb, input logic [3:0] alu,
                                     input logic ps, ill);
    return {pcw, mw, irw, rw, br, lord, rd, mr, sa, sb, alu, ps, ill};
  endfunction

  function automatic logic [4:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, A_ADD};
      6'b100010: return {1'b1, A_SUB};
      6'b100100: return {1'b1, A_AND};
      6'b100101: return {1'b1, A_OR};
      6'b100111: return {1'b1, A_NOR};
      6'b101010: return {1'b1, A_SLT};
      default:   return {1'b0, A_ADD};
    endcase
  endfunction

  // Expected per-cycle outputs for one whole instruction, FETCH first.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f);
    logic [4:0] fv;
    exp_q.push_back(mk(1,0,1,0,0,0,0,0,0,2'b01,A_ADD,0,0));
    if (o == T_LW || o == T_SW || o == T_RTYPE || o == T_BEQ || o == T_ADDI)
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,A_ADD,0,0));
    else
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,0,2'b11,A_ADD,0,1));
    if (o == T_LW) begin
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,A_ADD,0,0));
      exp_q.push_back(mk(0,0,0,0,0,1,0,0,0,2'b00,A_AND,0,0));
      exp_q.push_back(mk(0,0,0,1,0,0,0,1,0,2'b00,A_AND,0,0));
    end else if (o == T_SW) begin
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,A_ADD,0,0));
      exp_q.push_back(mk(0,1,0,0,0,1,0,0,0,2'b00,A_AND,0,0));
    end else if (o == T_RTYPE) begin
      fv = alu_of(f);
      if (fv[4]) begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,fv[3:0],0,0));
        exp_q.push_back(mk(0,0,0,1,0,0,1,0,0,2'b00,A_AND,0,0));
      end else begin
        exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,A_ADD,0,1));
      end
    end else if (o == T_BEQ) begin
      exp_q.push_back(mk(0,0,0,0,1,0,0,0,1,2'b00,A_SUB,1,0));
    end else if (o == T_ADDI) begin
      exp_q.push_back(mk(0,0,0,0,0,0,0,0,1,2'b10,A_ADD,0,0));
      exp_q.push_back(mk(0,0,0,1,0,0,0,0,0,2'b00,A_AND,0,0));
    end
  endtask

  // One clock: drive stall, sample at the falling edge, advance the model counters.
  task automatic cycle(input logic st, input logic is_fetch, output logic [16:0] o);
    stall = st;
    @(negedge clk);
    o = obs_w;
    @(posedge clk);
    #1;
    m_cycles++;
    if (is_fetch && !st) m_instrs++;
  endtask

  // Reset pulse, released just after a rising edge so INIT is seen for a full cycle.
  task automatic do_reset();
    stall = 1'b0;
    reset = 1'b0;
    #3;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cycles = 0;
    m_instrs = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [16:0] o;
    reset = 1'b0;
    #2;
    checks++;
    if (obs_w !== 17'd0) begin fails++; $display("FAIL reset_outputs: got %h expected %h", obs_w, 17'd0); end
    checks++;
    if (cycle_count !== '0 || instr_count !== '0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
    end
    do_reset();
    op = 6'b111111;
    cycle(1'b0, 1'b0, o);
    checks++;
    if (o !== 17'd0) begin fails++; $display("FAIL init_state: got %h expected %h", o, 17'd0); end
    push_instr(op, funct);
    while (exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      cycle(1'b0, e[14], o);
      checks++;
      if (o !== e) begin fails++; $display("FAIL first_fetch_illegal_op: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_mem();
    logic [16:0] o;
    logic [5:0] ops[3];
    ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_LW;
    do_reset();
    cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) begin
      op = ops[i];
      push_instr(op, funct);
      while (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        cycle(1'b0, e[14], o);
        checks++;
        if (o !== e) begin fails++; $display("FAIL mem_op%0h: got %h expected %h", op, o, e); end
      end
    end
  endtask

  task automatic test_r_type();
    logic [16:0] o;
    logic [5:0] fns[8];
    fns[0] = 6'b101010; fns[1] = 6'b111111; fns[2] = 6'b100000; fns[3] = 6'b100010;
    fns[4] = 6'b100100; fns[5] = 6'b100101; fns[6] = 6'b100111; fns[7] = 6'b000000;
    do_reset();
    cycle(1'b0, 1'b0, o);
    op = T_RTYPE;
    for (int i = 0; i < 8; i++) begin
      funct = fns[i];
      push_instr(op, funct);
      while (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        cycle(1'b0, e[14], o);
        checks++;
        if (o !== e) begin fails++; $display("FAIL rtype_funct%0h: got %h expected %h", funct, o, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] o;
    logic [5:0] ops[5];
    ops[0] = T_BEQ; ops[1] = T_ADDI; ops[2] = 6'b000010; ops[3] = T_BEQ; ops[4] = T_SW;
    do_reset();
    cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      op = ops[i];
      push_instr(op, funct);
      while (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        cycle(1'b0, e[14], o);
        checks++;
        if (o !== e) begin fails++; $display("FAIL b2b_op%0h: got %h expected %h", op, o, e); end
      end
    end
  endtask

  task automatic test_stall();
    logic [16:0] o, e;
    do_reset();
    cycle(1'b0, 1'b0, o);
    op = T_SW;
    push_instr(op, funct);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      cycle(1'b0, e[14], o);
      checks++;
      if (o !== e) begin fails++; $display("FAIL stall_lead%0d: got %h expected %h", i, o, e); end
    end
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, e[14], o);
      checks++;
      if (o !== (e & KEEP)) begin fails++; $display("FAIL stall_memwr%0d: got %h expected %h", i, o, e & KEEP); end
    end
    cycle(1'b0, e[14], o);
    checks++;
    if (o !== e) begin fails++; $display("FAIL stall_release: got %h expected %h", o, e); end
    push_instr(T_SW, funct);
    e = exp_q.pop_front();
    exp_q.delete();
    cycle(1'b0, e[14], o);
    checks++;
    if (o !== e) begin fails++; $display("FAIL stall_refetch: got %h expected %h", o, e); end
  endtask

  task automatic test_perf();
    logic [16:0] o;
    logic [5:0] ops[3];
    logic [CNT_W-1:0] exp_ic, exp_cc;
    ops[0] = T_SW; ops[1] = T_SW; ops[2] = T_BEQ;
    do_reset();
    cycle(1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) begin
      op = ops[i];
      push_instr(op, funct);
      while (exp_q.size() > 0) begin
        logic [16:0] e;
        e = exp_q.pop_front();
        cycle(1'b0, e[14], o);
      end
    end
    exp_ic = PERF_EN ? CNT_W'(3) : '0;
    exp_cc = PERF_EN ? CNT_W'(12) : '0;
    checks++;
    if (instr_count !== exp_ic) begin fails++; $display("FAIL perf_instr: got %0d expected %0d", instr_count, exp_ic); end
    checks++;
    if (cycle_count !== exp_cc) begin fails++; $display("FAIL perf_cycle: got %0d expected %0d", cycle_count, exp_cc); end
  endtask

  task automatic test_reset_mid();
    logic [16:0] o, e;
    do_reset();
    cycle(1'b0, 1'b0, o);
    op = T_LW;
    push_instr(op, funct);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      cycle(1'b0, e[14], o);
    end
    e = exp_q.pop_front();
    @(negedge clk);
    checks++;
    if (obs_w !== e) begin fails++; $display("FAIL mid_memwb: got %h expected %h", obs_w, e); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs_w !== 17'd0) begin fails++; $display("FAIL mid_reset_outputs: got %h expected %h", obs_w, 17'd0); end
    checks++;
    if (cycle_count !== '0 || instr_count !== '0) begin
      fails++; $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs_w !== 17'd0) begin fails++; $display("FAIL reset_held_edge: got %h expected %h", obs_w, 17'd0); end
    reset = 1'b1;
    m_cycles = 0;
    m_instrs = 0;
    exp_q.delete();
    cycle(1'b0, 1'b0, o);
    checks++;
    if (o !== 17'd0) begin fails++; $display("FAIL mid_reinit: got %h expected %h", o, 17'd0); end
  endtask

  task automatic test_random();
    logic [16:0] o, e;
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    logic [CNT_W-1:0] exp_ic, exp_cc;
    ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_RTYPE; ops[3] = T_BEQ; ops[4] = T_ADDI; ops[5] = T_RTYPE;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b100111; fns[5] = 6'b101010;
    do_reset();
    cycle(1'b0, 1'b0, o);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) funct = 6'($urandom);
      else funct = fns[$urandom_range(0, 5)];
      push_instr(op, funct);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        while ($urandom_range(0, 3) == 0) begin
          cycle(1'b1, e[14], o);
          checks++;
          if (o !== (e & KEEP)) begin fails++; $display("FAIL rand_stall op%0h fn%0h: got %h expected %h", op, funct, o, e & KEEP); end
        end
        cycle(1'b0, e[14], o);
        checks++;
        if (o !== e) begin fails++; $display("FAIL rand op%0h fn%0h: got %h expected %h", op, funct, o, e); end
      end
    end
    exp_ic = PERF_EN ? CNT_W'(m_instrs) : '0;
    exp_cc = PERF_EN ? CNT_W'(m_cycles) : '0;
    checks++;
    if (instr_count !== exp_ic) begin fails++; $display("FAIL rand_instr_count: got %0d expected %0d", instr_count, exp_ic); end
    checks++;
    if (cycle_count !== exp_cc) begin fails++; $display("FAIL rand_cycle_count: got %0d expected %0d", cycle_count, exp_cc); end
  endtask

  initial begin
    test_reset();
    test_mem();
    test_r_type();
    test_back_to_back();
    test_stall();
    test_perf();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mips_multi_control.md
# mips_multi_control

Moore-style main controller for the multicycle MIPS datapath. It decodes `Op`/`Funct` from the instruction register and sequences fetch, decode, execute, memory and writeback. It drives every datapath control input, one state per clock. It sits beside the datapath at the top level, and its outputs connect one-to-one to the datapath's control inputs.

## Interface
Parameters:
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  single clock; all state advances on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Op`  in  6  instruction [31:26].
- `Funct`  in  6  instruction [5:0].
- `Zero`  in  1  ALU zero flag. Informational only: branch gating is done in the datapath.
- `stall`  in  1  hold the current state and force all write enables low.
- `PC_write`, `Mem_write`, `IR_write`, `Reg_write`, `Branch`  out  1 each  write/branch enables.
- `lorD_mux`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `Reg_Dst_mux`  out  1  register destination: 0 = rt, 1 = rd.
- `Mem_reg_mux`  out  1  write-data select: 0 = ALUOut, 1 = memory data.
- `ALU_srcA_mux`  out  1  0 = PC, 1 = A.
- `ALU_srcB_mux`  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `ALU_control`  out  4  ALU operation code.
- `Pc_src_mux`  out  1  0 = ALU result, 1 = ALUOut.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `instr_count`, `cycle_count`  out  CNT_W each  performance counters (see Configuration).

## Operation
ALU codes:
- AND = 0000, OR = 0001, ADD = 0010, SUB = 0110, SLT = 0111, NOR = 1100.

States and outputs. Any output not listed is 0.
- INIT: all outputs 0. Next state is FETCH.
- FETCH: IR_write=1, PC_write=1, lorD=0, SrcA=0, SrcB=01, ALU=ADD, Pc_src=0. Next state is DECODE.
- DECODE: SrcA=0, SrcB=11, ALU=ADD; the branch target goes to ALUOut. Next state by `Op`:
  - 000000 → EXEC_R
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDI_EX
  - any other opcode → FETCH, with `illegal_op` asserted during DECODE.
- MEMADR: SrcA=1, SrcB=10, ALU=ADD. Next state: lw → MEMRD, sw → MEMWR.
- MEMRD: lorD=1. Next state is MEMWB.
- MEMWB: Reg_write=1, Reg_Dst=0, Mem_reg=1. Next state is FETCH.
- MEMWR: lorD=1, Mem_write=1. Next state is FETCH.
- EXEC_R: SrcA=1, SrcB=00, ALU from funct decode:
  - 100000 = ADD, 100010 = SUB, 100100 = AND, 100101 = OR, 100111 = NOR, 101010 = SLT.
  - Known funct → ALU_WB.
  - Unknown funct → FETCH, with `illegal_op` asserted and ALU=ADD.
- ALU_WB: Reg_write=1, Reg_Dst=1, Mem_reg=0. Next state is FETCH.
- BRANCH: SrcA=1, SrcB=00, ALU=SUB, Pc_src=1, Branch=1. Next state is FETCH.
- ADDI_EX: SrcA=1, SrcB=10, ALU=ADD. Next state is ADDI_WB.
- ADDI_WB: Reg_write=1, Reg_Dst=0, Mem_reg=0. Next state is FETCH.

Stall:
- The state register holds.
- PC_write, Mem_write, IR_write, Reg_write, Branch and `illegal_op` are forced to 0.
- Mux selects and ALU_control keep the values of the held state.

## Timing
- Reset asserted: state is INIT, all outputs 0, counters 0, asynchronously.
- First edge after reset deasserts: INIT → FETCH. First fetch occurs on the second edge.
- Instruction latency in cycles, FETCH through the last state:
  - lw 5; sw 4; R-type 4; addi 4; beq 3.
  - illegal opcode 2; illegal funct 3.
- Reset mid-instruction: the instruction is abandoned immediately; no write enable may glitch high.
- Outputs are a pure function of the state and the `stall`/`Op`/`Funct` inputs. No output depends combinationally on `Zero`.

## Configuration
`MIPS_MULTI_CTRL_PERF_EN` defined:
- `cycle_count` increments on every non-reset edge, wrapping at 2^CNT_W.
- `instr_count` increments on each non-stalled FETCH edge.

Undefined:
- Both counter ports remain, tied to 0; no counter flops are built.

## Structure
- Package `mips_multi_pkg` holds:
  - the state enum;
  - the opcode and funct constants;
  - the ALU_control codes;
  - the ALU_srcB select constants.
- One combinational sub-module, `mips_alu_decoder`: Funct → ALU_control plus a valid flag. It is instantiated once for EXEC_R.

## Test plan
- Reset low, then release → INIT for one cycle with all outputs 0; the next cycle is FETCH with IR_write=PC_write=1, SrcB=01.
- Op=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MEMWB has Reg_write=1, Mem_reg=1, Reg_Dst=0; 5 cycles total.
- Op=000000, Funct=101010 → EXEC_R with ALU_control=0111, then ALU_WB with Reg_Dst=1; Funct=111111 instead → `illegal_op` pulse, back to FETCH after 3 cycles.
- Op=000100 → BRANCH with Branch=1, ALU=0110, Pc_src=1, then FETCH.
- `stall` held 3 cycles in MEMWR → Mem_write=0 throughout; state kept; Mem_write=1 on the cycle after release.
- With `MIPS_MULTI_CTRL_PERF_EN`, run 2 sw plus 1 beq → `instr_count`=3 and `cycle_count`=12 including INIT. Without the macro → both counters read 0.
